// File: rtl/accel_cmd_sequencer.sv
// Issues one register-window command to the accelerator, then waits for done, timeout or abort.
// Latency: the start pulse comes one cycle after the start edge; status settles one cycle after done, timeout or abort.
// Backpressure: the start is held off while accel_ready is low, and new start edges are dropped while a command is in flight.
module accel_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cmd_in,
    input  logic [31:0] arg0_in,
    input  logic [31:0] arg1_in,
    input  logic        accel_ready,
    input  logic        accel_done,
    input  logic        accel_err,
    input  logic [31:0] accel_result,
    output logic        accel_start,
    output logic        accel_abort,
    output logic [3:0]  accel_op,
    output logic [31:0] accel_arg0,
    output logic [31:0] accel_arg1,
    output logic [31:0] status_out,
    output logic [31:0] result_out,
    output logic        polling
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [1:0]       state;
    logic             start_q;
    logic [CNT_W-1:0] cnt;
    logic             busy_f;
    logic             done_f;
    logic             err_f;
    logic             timeout_f;
    logic             aborted_f;
    logic [7:0]       cmd_cnt;

    logic start_rise;
    logic active;
    logic done_hit;
    logic timeout_hit;
    logic abort_req;
    logic kill;

    logic unused_cmd_bits;
    assign unused_cmd_bits = ^{cmd_in[30:8], cmd_in[3:2]};

    assign start_rise  = cmd_in[0] & ~start_q;
    assign active      = (state == S_ISSUE) || (state == S_RUN);
    assign done_hit    = (state == S_RUN) && accel_done;
    assign timeout_hit = active && (cnt == CNT_LAST);
    assign abort_req   = active && cmd_in[31];
    // A same-cycle done beats timeout and abort; a kill in ISSUE also suppresses the start.
    assign kill        = (timeout_hit || abort_req) && !done_hit;

    assign accel_start = (state == S_ISSUE) && accel_ready && !kill;
    assign accel_abort = kill;

    assign status_out = {16'h0000, cmd_cnt, 3'b000, aborted_f, timeout_f, err_f, done_f, busy_f};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            start_q    <= 1'b0;
            cnt        <= '0;
            busy_f     <= 1'b0;
            done_f     <= 1'b0;
            err_f      <= 1'b0;
            timeout_f  <= 1'b0;
            aborted_f  <= 1'b0;
            cmd_cnt    <= 8'd0;
            accel_op   <= 4'd0;
            accel_arg0 <= 32'd0;
            accel_arg1 <= 32'd0;
            result_out <= 32'd0;
            polling    <= 1'b0;
        end else begin
            start_q <= cmd_in[0];
            case (state)
                S_IDLE: begin
                    if (start_rise) begin
                        accel_op   <= cmd_in[7:4];
                        accel_arg0 <= arg0_in;
                        accel_arg1 <= arg1_in;
                        polling    <= cmd_in[1];
                        busy_f     <= 1'b1;
                        done_f     <= 1'b0;
                        err_f      <= 1'b0;
                        timeout_f  <= 1'b0;
                        aborted_f  <= 1'b0;
                        cnt        <= '0;
                        state      <= S_ISSUE;
                    end
                end
                S_ISSUE, S_RUN: begin
                    if (done_hit) begin
                        result_out <= accel_result;
                        done_f     <= 1'b1;
                        err_f      <= accel_err;
                        cmd_cnt    <= cmd_cnt + 8'd1;
                        state      <= S_DONE;
                    end else if (kill) begin
                        timeout_f <= timeout_hit;
                        aborted_f <= abort_req;
                        err_f     <= 1'b1;
                        state     <= S_DONE;
                    end else if ((state == S_ISSUE) && accel_ready) begin
                        cnt   <= '0;
                        state <= S_RUN;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    busy_f  <= 1'b0;
                    polling <= 1'b0;
                    state   <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_cmd_sequencer.sv
// Directed bench: stimulus pushes expected issue/completion records, a negedge monitor pops and compares.
module tb_accel_cmd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cmd_in = '0;
    logic [31:0] arg0_in = '0;
    logic [31:0] arg1_in = '0;
    logic        accel_ready = 1'b0;
    logic        accel_done = 1'b0;
    logic        accel_err = 1'b0;
    logic [31:0] accel_result = '0;
    logic        accel_start;
    logic        accel_abort;
    logic [3:0]  accel_op;
    logic [31:0] accel_arg0;
    logic [31:0] accel_arg1;
    logic [31:0] status_out;
    logic [31:0] result_out;
    logic        polling;

    accel_cmd_sequencer #(.TIMEOUT_CYCLES(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cmd_in(cmd_in), .arg0_in(arg0_in), .arg1_in(arg1_in),
        .accel_ready(accel_ready), .accel_done(accel_done), .accel_err(accel_err),
        .accel_result(accel_result), .accel_start(accel_start), .accel_abort(accel_abort),
        .accel_op(accel_op), .accel_arg0(accel_arg0), .accel_arg1(accel_arg1),
        .status_out(status_out), .result_out(result_out), .polling(polling)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a0;
        logic [31:0] a1;
    } iss_t;

    typedef struct {
        logic [31:0] status;
        logic [31:0] result;
        int          starts;
        int          aborts;
        int          gap;
        logic        poll;
    } cmp_t;

    iss_t exp_iss[$];
    cmp_t exp_cmp[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor state
    int   cyc_n = 0;
    int   starts = 0;
    int   aborts = 0;
    int   last_start = 0;
    int   gap = 0;
    logic poll_seen = 1'b0;
    logic prev_busy = 1'b0;

    always @(negedge clk) begin
        iss_t ie;
        cmp_t ce;
        cyc_n++;
        if (rst) begin
            starts = 0; aborts = 0; gap = 0; poll_seen = 1'b0; prev_busy = 1'b0;
        end else begin
            if (polling) poll_seen = 1'b1;
            if (accel_start) begin
                starts++;
                last_start = cyc_n;
                check("start_needs_ready", 32'(accel_ready), 32'd1);
                if (exp_iss.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_start: got start pulse, expected none (op %h)", accel_op);
                end else begin
                    ie = exp_iss.pop_front();
                    check("issue_op", 32'(accel_op), 32'(ie.op));
                    check("issue_arg0", accel_arg0, ie.a0);
                    check("issue_arg1", accel_arg1, ie.a1);
                end
            end
            if (accel_abort) begin
                aborts++;
                gap = cyc_n - last_start;
            end
            if (prev_busy && !status_out[0]) begin
                if (exp_cmp.size() == 0) begin
                    tests++; fails++;
                    $display("FAIL unexpected_completion: got status %h, expected none", status_out);
                end else begin
                    ce = exp_cmp.pop_front();
                    check("cmp_status", status_out, ce.status);
                    check("cmp_result", result_out, ce.result);
                    check("cmp_starts", 32'(starts), 32'(ce.starts));
                    check("cmp_aborts", 32'(aborts), 32'(ce.aborts));
                    check("cmp_polling_seen", 32'(poll_seen), 32'(ce.poll));
                    check("cmp_polling_after", 32'(polling), 32'd0);
                    if (ce.aborts > 0) check("cmp_abort_gap", 32'(gap), 32'(ce.gap));
                end
                starts = 0; aborts = 0; gap = 0; poll_seen = 1'b0;
            end
            prev_busy = status_out[0];
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] op, input logic [31:0] a0, input logic [31:0] a1,
                        input logic [31:0] st, input logic [31:0] res,
                        input int ab, input int g, input logic pl);
        iss_t ie;
        cmp_t ce;
        ie.op = op; ie.a0 = a0; ie.a1 = a1;
        exp_iss.push_back(ie);
        ce.status = st; ce.result = res; ce.starts = 1; ce.aborts = ab; ce.gap = g; ce.poll = pl;
        exp_cmp.push_back(ce);
    endtask

    task automatic do_cmd(input logic [31:0] cmd, input logic [31:0] a0, input logic [31:0] a1,
                          input int rdly, input int run_n, input bit give_done,
                          input logic [31:0] res, input bit err, input bit abort, input int tail);
        arg0_in = a0;
        arg1_in = a1;
        accel_ready = (rdly == 0);
        cmd_in = cmd;
        cyc(1);
        repeat (rdly) cyc(1);
        accel_ready = 1'b1;
        cyc(1);
        repeat (run_n) cyc(1);
        if (give_done) begin
            accel_done = 1'b1; accel_result = res; accel_err = err;
        end
        if (abort) cmd_in[31] = 1'b1;
        if (give_done || abort) begin
            cyc(1);
            accel_done = 1'b0; accel_err = 1'b0; cmd_in[31] = 1'b0;
        end
        cmd_in = '0;
        cyc(tail);
    endtask

    initial begin
        #2;
        check("rst_start", 32'(accel_start), 32'd0);
        check("rst_abort", 32'(accel_abort), 32'd0);
        check("rst_status", status_out, 32'd0);
        check("rst_result", result_out, 32'd0);
        check("rst_polling", 32'(polling), 32'd0);
        cyc(1);
        rst = 1'b0;
        cyc(2);
        check("idle_status", status_out, 32'd0);

        // Basic non-blocking, done on the fifth RUN cycle
        push(4'd3, 32'hA, 32'hB, 32'h0000_0102, 32'h1234, 0, 0, 1'b0);
        do_cmd(32'h0000_0031, 32'hA, 32'hB, 0, 4, 1'b1, 32'h1234, 1'b0, 1'b0, 4);

        // Blocking with ready held low for three ISSUE cycles
        push(4'd1, 32'h11, 32'h22, 32'h0000_0202, 32'h55AA, 0, 0, 1'b1);
        do_cmd(32'h0000_0013, 32'h11, 32'h22, 3, 2, 1'b1, 32'h55AA, 1'b0, 1'b0, 4);

        // Timeout: no done, abort eight cycles after the start pulse, result untouched
        accel_result = 32'hDEAD_BEEF;
        push(4'd2, 32'h33, 32'h44, 32'h0000_020C, 32'h55AA, 1, 8, 1'b0);
        do_cmd(32'h0000_0021, 32'h33, 32'h44, 0, 0, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b0, 12);

        // Abort and done in the same RUN cycle: done wins
        push(4'd4, 32'h55, 32'h66, 32'h0000_0302, 32'h0BAD, 0, 0, 1'b0);
        do_cmd(32'h0000_0041, 32'h55, 32'h66, 0, 3, 1'b1, 32'h0BAD, 1'b0, 1'b1, 4);

        // Abort alone on the third RUN cycle
        push(4'd5, 32'h77, 32'h88, 32'h0000_0314, 32'h0BAD, 1, 3, 1'b0);
        do_cmd(32'h0000_0051, 32'h77, 32'h88, 0, 2, 1'b0, 32'h0, 1'b0, 1'b1, 4);

        // Reset asserted mid-RUN of a blocking command
        begin
            iss_t ie;
            ie.op = 4'd7; ie.a0 = 32'h99; ie.a1 = 32'hAA;
            exp_iss.push_back(ie);
        end
        arg0_in = 32'h99; arg1_in = 32'hAA; accel_ready = 1'b1;
        cmd_in = 32'h0000_0073;
        cyc(4);
        #3 rst = 1'b1;
        #2;
        check("midrst_start", 32'(accel_start), 32'd0);
        check("midrst_abort", 32'(accel_abort), 32'd0);
        check("midrst_op", 32'(accel_op), 32'd0);
        check("midrst_arg0", accel_arg0, 32'd0);
        check("midrst_arg1", accel_arg1, 32'd0);
        check("midrst_status", status_out, 32'd0);
        check("midrst_result", result_out, 32'd0);
        check("midrst_polling", 32'(polling), 32'd0);
        cmd_in = '0;
        cyc(2);
        rst = 1'b0;
        cyc(2);

        // Start held high across a long window, toggled once during RUN
        push(4'd6, 32'h6, 32'h66, 32'h0000_0102, 32'h600D, 0, 0, 1'b0);
        arg0_in = 32'h6; arg1_in = 32'h66; accel_ready = 1'b1;
        cmd_in = 32'h0000_0061;
        cyc(2);
        cmd_in[0] = 1'b0;
        cyc(1);
        cmd_in[0] = 1'b1;
        cyc(1);
        accel_done = 1'b1; accel_result = 32'h600D;
        cyc(1);
        accel_done = 1'b0;
        cyc(20);
        cmd_in = '0;
        cyc(2);

        // Fresh edge after DONE issues a second command; count reaches 2
        push(4'd8, 32'h123, 32'h456, 32'h0000_0202, 32'h0777, 0, 0, 1'b0);
        do_cmd(32'h0000_0081, 32'h123, 32'h456, 0, 1, 1'b1, 32'h0777, 1'b0, 1'b0, 4);

        check("iss_queue_empty", 32'(exp_iss.size()), 32'd0);
        check("cmp_queue_empty", 32'(exp_cmp.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/accel_cmd_sequencer.md
Name: accel_cmd_sequencer

Overview:
Sequences one accelerator command at a time on behalf of the processor core. It watches a command word written through the accelerator register window and issues it to the face-filter accelerator with a start/ready handshake. It then waits for done, with a timeout, and returns status and result words to the register window. It drives the core's polling stall for blocking commands.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles in RUN before timeout abort; legal range 1..65535
CNT_W, 16, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
cmd_in  in  32  command word: [0] start, [1] blocking, [7:4] opcode, [31] abort
arg0_in  in  32  argument word 0
arg1_in  in  32  argument word 1
accel_ready  in  1  accelerator can accept a start
accel_done  in  1  one-cycle completion pulse
accel_err  in  1  error flag, sampled only with accel_done
accel_result  in  32  result, valid with accel_done
accel_start  out  1  one-cycle start pulse
accel_abort  out  1  one-cycle abort pulse
accel_op  out  4  latched opcode
accel_arg0  out  32  latched arg0
accel_arg1  out  32  latched arg1
status_out  out  32  [0] busy, [1] done, [2] err, [3] timeout, [4] aborted, [15:8] completed-command count, rest 0
result_out  out  32  last accepted result
polling  out  1  core stall request

Behaviour:
- Reset values: all outputs 0; state IDLE; start-edge register 0; counter 0.
- Start detect: start_rise = cmd_in[0] & ~start_q. start_q is registered every cycle. Only the rising edge is a request; a held 1 never retriggers.
- IDLE:
  - On start_rise, latch opcode, arg0, arg1 and the blocking bit.
  - Clear status bits [1..4]. Set busy.
  - Go to ISSUE next cycle.
  - start_rise in any other state is ignored. It is not queued.
- ISSUE:
  - accel_start = accel_ready, combinationally gated by the state register. The start pulse lasts exactly one cycle.
  - When accel_ready = 1, go to RUN and clear the counter.
  - The timeout counter also runs in ISSUE.
- RUN:
  - The counter increments each cycle.
  - accel_done = 1: latch accel_result into result_out, set done, set err = accel_err, increment count [15:8] (wraps 255 -> 0), then go to DONE.
  - accel_done has priority over timeout and abort in the same cycle.
- Timeout: when the counter reaches TIMEOUT_CYCLES-1 in ISSUE or RUN without done:
  - pulse accel_abort for one cycle;
  - set timeout and err; result_out is unchanged; count is not incremented;
  - go to DONE.
- Abort: cmd_in[31] = 1 in ISSUE or RUN, with no done that cycle:
  - pulse accel_abort; set aborted and err; go to DONE.
  - cmd_in[31] in IDLE or DONE has no effect.
- DONE: lasts one cycle, clears busy, then returns to IDLE. A start_rise seen in DONE is ignored.
- polling: registered; 1 from the cycle after a blocking command is accepted until the cycle after DONE. Never 1 for non-blocking commands.
- accel_done in IDLE, ISSUE or DONE is ignored; it produces no status change.
- Reset asserted mid-command: immediate return to IDLE and all-zero outputs. No abort pulse is generated; the accelerator has its own reset.
- Done/err/timeout/aborted are sticky until the next accepted command.
- Count is cleared only by reset.

Test Plan:
- Basic non-blocking: cmd_in 0x0000_0031 with arg0 = 0xA, arg1 = 0xB, ready held 1, done after 5 cycles with result 0x1234 -> exactly one start pulse; accel_op = 3; result_out = 0x1234; status_out = 0x0000_0102; polling stays 0.
- Blocking plus ready delay: cmd 0x0000_0013 with ready low for 3 cycles -> start asserted on the first cycle ready = 1; polling = 1 through DONE, then 0; busy clears.
- Timeout: TIMEOUT_CYCLES = 8, done never arrives -> one accel_abort pulse 8 cycles after entering ISSUE; status_out[3:2] = 2'b11; count unchanged; result_out holds its previous value.
- Abort vs done: cmd_in[31] and accel_done in the same RUN cycle -> done wins; aborted = 0; no abort pulse. Repeat with abort alone -> status_out[4] = 1, err = 1.
- Edge detect and ignore: hold cmd_in[0] = 1 across two full commands' worth of cycles -> only one command issued. Toggle start during RUN -> ignored. Toggle after DONE -> new command; count = 2.
- Reset mid-RUN: assert rst asynchronously -> all outputs 0 within the same cycle; next start_rise operates normally; count restarts at 0.
